zigbee_phase_slicer: RTL
========================

// Module: zigbee_phase_slicer
// PURPOSE
//  Downstream neighbour of the CORDIC vectoring pipeline: consumes the final-stage phase (wout)
//  of each registered I/Q sample and differentiates it sample to sample (instantaneous frequency).
//  Integrates SPC phase deltas per chip (integrate-and-dump) and slices the sign into an
//  O-QPSK/MSK chip decision for the ZigBee despreader.
//  Streaming, valid-qualified, no backpressure.
// PARAMETERS
//  W_SIZE  10  phase width; two's complement, full circle = 2^W_SIZE LSB (pi = 2^(W_SIZE-1))
//  SPC     4   phase deltas integrated per chip (>=2)
//  ACC_W   W_SIZE+$clog2(SPC)  accumulator / metric width (derived localparam, not overridable)
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  rst_n        in   1       synchronous reset, active low
//  phase_valid  in   1       phase_in valid this cycle (from CORDIC output register)
//  phase_in     in   W_SIZE  signed phase of current sample
//  resync       in   1       one-cycle pulse: restart chip boundary (from preamble/SFD timing)
//  chip_valid   out  1       one-cycle pulse, chip_bit/chip_metric valid
//  chip_bit     out  1       1 = accumulated phase advance > 0, else 0 (ties -> 0)
//  chip_metric  out  ACC_W   signed sum of the SPC deltas for the chip just sliced
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=EMPTY, prev=0, cnt=0, acc=0; chip_valid=0, chip_bit=0,
//    chip_metric=0. Reset mid-chip discards the partial accumulation, no output pulse.
//  - FSM: EMPTY (no previous phase held) / RUN.
//    EMPTY + phase_valid -> prev<=phase_in, ->RUN, no delta produced.
//    RUN + phase_valid -> delta = phase_in - prev modulo 2^W_SIZE (W_SIZE-bit wrap, signed,
//    range [-pi, pi)); prev<=phase_in; acc+=sign-extended delta; cnt++.
//  - Wrap-around: +pi->-pi crossing yields small delta by modular arithmetic; no unwrap logic.
//  - Dump: on the valid cycle where cnt reaches SPC-1 (SPC-th delta), next edge registers
//    chip_metric = acc + delta, chip_bit = (that sum > 0), chip_valid=1 for exactly one cycle.
//    Same edge: acc<=0, cnt<=0. Latency = 1 clk from SPC-th phase_valid to chip_valid.
//  - Consecutive chips contiguous: the sample closing chip n is the prev for chip n+1's
//    first delta (no sample lost).
//  - phase_valid=0: all state held, chip_valid=0. Gaps of any length tolerated.
//  - resync=1 (with or without phase_valid): acc<=0, cnt<=0, pending dump suppressed.
//    With phase_valid: prev<=phase_in, state=RUN; without: state=EMPTY.
//    resync wins over a coincident dump.
//  - Accumulator cannot overflow: |sum| <= SPC*2^(W_SIZE-1) fits ACC_W signed.
//  - No X propagation: outputs defined every cycle after first reset.
// STRUCTURE
//  - zigbee_demod_pkg: W_SIZE_DEF, SPC_DEF, typedef logic signed [W_SIZE-1:0] phase_t,
//    typedef enum logic {ST_EMPTY, ST_RUN} slicer_state_e.
//  - Sub-module zigbee_phase_delta (combinational): modular W_SIZE-bit subtraction,
//    signed out. Reused later by the frequency-offset estimator.
//  - Top: FSM, prev register, cnt, acc, output registers.
// TESTING (W_SIZE=10, SPC=4)
//  1 Constant phase 100 x 9 valid samples -> 2 chip_valid pulses, metric 0, chip_bit 0.
//  2 Ramp +16/sample from 0, 5 samples -> one pulse 1 clk after 5th, metric +64, bit 1;
//    ramp -16 -> metric -64, bit 0.
//  3 Wrap: 480,500,-500,-480,-460 -> deltas 20,24,20,20 -> metric +84, bit 1 (no spurious
//    -1000).
//  4 Gappy valid (1 of 3 cycles) on test 2 ramp -> identical metric; chip_valid exactly 1 clk.
//  5 rst_n low after 2 deltas, then ramp -> first pulse only after 1 prime + 4 deltas.
//    All outputs 0 in reset.
//  6 resync coincident with the 4th delta's valid -> no pulse; that sample becomes prev;
//    next pulse after 4 more deltas.

Source files
------------

// File: rtl/zigbee_demod_pkg.sv
// Shared types and defaults for the ZigBee O-QPSK demodulator datapath.
// Phase values are two's complement with a full circle of 2^W_SIZE LSB.
package zigbee_demod_pkg;

  localparam int W_SIZE_DEF = 10;
  localparam int SPC_DEF    = 4;

  typedef logic signed [W_SIZE_DEF-1:0] phase_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_RUN   = 1'b1
  } slicer_state_e;

endpackage

// File: rtl/zigbee_phase_delta.sv
// Modular phase difference: cur - prev wrapped to W_SIZE bits, read as signed [-pi, pi).
// Purely combinational so both the slicer and the frequency-offset estimator can share it.
module zigbee_phase_delta #(
  parameter int W_SIZE = 10
) (
  input  logic signed [W_SIZE-1:0] i_cur,
  input  logic signed [W_SIZE-1:0] i_prev,
  output logic signed [W_SIZE-1:0] o_delta
);

  // Truncation to W_SIZE bits is the phase unwrap: a +pi -> -pi crossing stays small.
  assign o_delta = i_cur - i_prev;

endmodule

// File: rtl/zigbee_phase_slicer.sv
// Differentiates CORDIC phase sample to sample, integrates SPC deltas per chip
// and slices the sign of the sum into an MSK chip decision.
module zigbee_phase_slicer
  import zigbee_demod_pkg::*;
#(
  parameter  int W_SIZE = W_SIZE_DEF,
  parameter  int SPC    = SPC_DEF,
  localparam int ACC_W  = W_SIZE + $clog2(SPC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              phase_valid,
  input  logic [W_SIZE-1:0] phase_in,
  input  logic              resync,
  output logic              chip_valid,
  output logic              chip_bit,
  output logic [ACC_W-1:0]  chip_metric
);

  localparam int CNT_W = $clog2(SPC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPC - 1);

  slicer_state_e             r_state;
  logic signed [W_SIZE-1:0]  r_prev;
  logic [CNT_W-1:0]          r_cnt;
  logic signed [ACC_W-1:0]   r_acc;
  logic                      r_chip_valid;
  logic                      r_chip_bit;
  logic signed [ACC_W-1:0]   r_chip_metric;

  logic signed [W_SIZE-1:0]  w_delta;
  logic signed [ACC_W-1:0]   w_delta_ext;
  logic signed [ACC_W-1:0]   w_sum;

  zigbee_phase_delta #(
    .W_SIZE (W_SIZE)
  ) u_delta (
    .i_cur   (phase_in),
    .i_prev  (r_prev),
    .o_delta (w_delta)
  );

  assign w_delta_ext = {{(ACC_W-W_SIZE){w_delta[W_SIZE-1]}}, w_delta};
  assign w_sum       = r_acc + w_delta_ext;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_EMPTY;
      r_prev        <= '0;
      r_cnt         <= '0;
      r_acc         <= '0;
      r_chip_valid  <= 1'b0;
      r_chip_bit    <= 1'b0;
      r_chip_metric <= '0;
    end else begin
      r_chip_valid <= 1'b0;
      // resync restarts the chip boundary and overrides any dump due this cycle.
      if (resync) begin
        r_acc <= '0;
        r_cnt <= '0;
        if (phase_valid) begin
          r_prev  <= phase_in;
          r_state <= ST_RUN;
        end else begin
          r_state <= ST_EMPTY;
        end
      end else if (phase_valid) begin
        r_prev <= phase_in;
        if (r_state == ST_EMPTY) begin
          r_state <= ST_RUN;
        end else if (r_cnt == CNT_LAST) begin
          r_chip_valid  <= 1'b1;
          r_chip_bit    <= (w_sum > 0);
          r_chip_metric <= w_sum;
          r_acc         <= '0;
          r_cnt         <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign chip_valid  = r_chip_valid;
  assign chip_bit    = r_chip_bit;
  assign chip_metric = r_chip_metric;

endmodule
